// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state encoding and a compare-op helper
// used by the arbiter and its ALU.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_SHL = 4'b0010;
  localparam logic [3:0] OP_SHR = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b0011;
  localparam logic [3:0] OP_OR  = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b1100;
  localparam logic [3:0] OP_GT  = 4'b1001;
  localparam logic [3:0] OP_LT  = 4'b0101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MULW = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  function automatic logic is_cmp(input logic [3:0] op);
    return (op == OP_EQ) || (op == OP_GT) || (op == OP_LT);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU. Outputs are unmasked: the caller decides
// whether the result or the compare flag is meaningful for an opcode.
module alu
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        branch
);

  logic big_shift;
  assign big_shift = |b[31:5];

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    result = a + b;
    branch = (a == b);
    case (op)
      OP_SUB:  result = a - b;
      OP_SHL:  result = big_shift ? 32'd0 : (a << b[4:0]);
      OP_SHR:  result = big_shift ? 32'd0 : (a >> b[4:0]);
      OP_MUL:  result = a * b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      default: result = a + b;
    endcase
    case (op)
      OP_GT:   branch = (a > b);
      OP_LT:   branch = (a < b);
      default: branch = (a == b);
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end sharing one ALU, one operation in flight,
// round-robin tie-break and a shared result bus.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int MUL_EXTRA = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        resp0_valid,
  output logic        resp1_valid,
  input  logic        resp0_ready,
  input  logic        resp1_ready,
  output logic [31:0] resp_result,
  output logic        resp_branch
);

  localparam logic [1:0] MUL_LOAD = (MUL_EXTRA > 0) ? 2'(MUL_EXTRA - 1) : 2'd0;

  logic [1:0]  state;
  logic        prio;
  logic [1:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [3:0]  op_q;
  logic        id_q;

  logic        idle;
  logic        gnt_id;
  logic        accept;
  logic [3:0]  acc_op;
  logic [31:0] alu_result;
  logic        alu_branch;
  logic        resp_take;

  // prio=1 lets requester 1 win a tie; a lone valid always wins.
  assign idle       = (state == ST_IDLE) && !rst;
  assign gnt_id     = req1_valid && (!req0_valid || prio);
  assign req0_ready = idle && req0_valid && !gnt_id;
  assign req1_ready = idle && gnt_id;
  assign accept     = req0_ready || req1_ready;
  assign acc_op     = gnt_id ? req1_op : req0_op;

  assign resp0_valid = (state == ST_RESP) && !id_q;
  assign resp1_valid = (state == ST_RESP) && id_q;
  assign resp_take   = id_q ? resp1_ready : resp0_ready;

  alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .branch (alu_branch)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      prio        <= 1'b0;
      cnt         <= 2'd0;
      resp_result <= 32'd0;
      resp_branch <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            prio <= ~gnt_id;
            if ((acc_op == OP_MUL) && (MUL_EXTRA > 0)) begin
              cnt   <= MUL_LOAD;
              state <= ST_MULW;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_MULW: begin
          if (cnt == 2'd0) state <= ST_EXEC;
          else             cnt   <= cnt - 2'd1;
        end
        ST_EXEC: begin
          resp_result <= is_cmp(op_q) ? 32'd0 : alu_result;
          resp_branch <= is_cmp(op_q) && alu_branch;
          state       <= ST_RESP;
        end
        default: begin
          if (resp_take) state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: operand/id capture registers carry no reset; they are only read
  // after an accept has loaded them, so a reset would buy nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= gnt_id ? req1_a : req0_a;
      b_q  <= gnt_id ? req1_b : req0_b;
      op_q <= acc_op;
      id_q <= gnt_id;
    end
  end

endmodule
